crc_byte_feeder: RTL
====================

# crc_byte_feeder

Byte-stream front end for the CRC peripheral. Accepts 1-, 2- or 4-byte pushes from the bus, buffers them in a small byte FIFO, and issues them one byte at a time as 8-bit DATA or REFL writes into the CRC engine whenever its STAT ready bit is high. Software can then post whole words without polling the engine between bytes.

## Interface

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of two, at least 4
- LW, $clog2(DEPTH)+1, width of the level output (derived)

Ports:
- clk  in  1  peripheral clock (64 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  push request, one cycle per request
- wr_len  in  2  bytes in the push: 00 = 1, 01 = 2, 10 = 4, 11 = no push (same encoding as data_write_n)
- wr_data  in  32  push data; byte 0 = wr_data[7:0] is pushed first
- wr_reflect  in  1  tags every byte of this push as reflected
- flush  in  1  clears the FIFO and overflow, returns the FSM to IDLE
- crc_ready  in  1  CRC engine STAT bit 0 (1 = idle)
- crc_cs  out  1  one-cycle write strobe to the CRC engine
- crc_rs  out  2  10 = DATA, 11 = REFL
- crc_wrl  out  4  always 0001 when crc_cs = 1; 0000 otherwise
- crc_d  out  32  {24'b0, byte}; all zeros when crc_cs = 0
- level  out  LW  bytes currently buffered, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- overflow  out  1  sticky: a push was rejected
- done  out  1  empty, FSM in IDLE, and crc_ready = 1

## Operation

- FIFO entries are 9 bits wide: {reflect, byte}. Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. level is kept as a separate counter.
- Push acceptance is all-or-nothing. A push is accepted if (DEPTH − level) ≥ n, where n is the byte count and level is the value at the start of the cycle. A pop in the same cycle does not add free space.
- Rejected push: no bytes are written and overflow is set to 1. wr_en with wr_len = 11 is ignored and does not set overflow.
- Accepted push: bytes are written in order 0..n−1 at consecutive pointer positions, with wrap-around allowed.
- FSM states and transitions:
  - IDLE → ISSUE when !empty and crc_ready.
  - ISSUE, held for 1 cycle: crc_cs = 1, crc_rs = {1, reflect}, crc_d[7:0] = head byte; pop the head. Next state is HOLD.
  - HOLD, held for 1 cycle: crc_ready is ignored, covering the engine's counter load. Next state is BUSY.
  - BUSY → IDLE when crc_ready = 1.
- crc_cs, crc_rs, crc_wrl and crc_d are registered and decoded from the state register plus the head entry. No combinational path runs from crc_ready to crc_cs.
- Push and pop in the same cycle: level becomes level + n − 1.
- flush has priority over push and pop. Flush cycle effects:
  - pointers and level go to 0, overflow goes to 0, state goes to IDLE;
  - a push in the same cycle is discarded and does not set overflow.
  - If flush arrives in ISSUE, the strobe already in flight completes. A byte already handed to the engine is not recalled.
- Reset values: state IDLE, pointers 0, level 0, empty 1, full 0, overflow 0, crc_cs 0, crc_rs 00, crc_wrl 0000, crc_d 0. done = 1 once crc_ready = 1.

## Timing

- A push in cycle N is visible in level and empty at cycle N+1.
- From empty with the engine idle: push at cycle N gives IDLE → ISSUE evaluation at N+1 and crc_cs = 1 at N+2.
- The engine shifts 8 cycles per byte. Steady-state spacing between successive crc_cs pulses is 10 cycles: ISSUE, HOLD, 7 BUSY cycles, 1 IDLE cycle.
- The pop takes effect at the end of the ISSUE cycle, so level decrements at cycle ISSUE+1.
- overflow sets in the cycle after the rejected push and stays set until flush or reset.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and crc_cs drops without waiting for a clock edge.

## Test plan

- Reset, then push 4 bytes 0x44332211 with reflect = 0 → crc_cs pulses with crc_d[7:0] = 11, 22, 33, 44 in that order, crc_rs = 10, pulses 10 cycles apart; level counts 4→0; done = 1 after the last byte.
- Push 2 bytes 0x00008001 with reflect = 1, crc_ready tied to 1 → two pulses with crc_rs = 11 and bytes 01, 80; HOLD still separates the pulses.
- DEPTH = 8: push 4, push 4 with crc_ready = 0 → full = 1, level = 8. A further 1-byte push → overflow = 1, level stays 8, FIFO contents unchanged.
- With level = 6, issue a 2-byte push in the same cycle as an ISSUE pop → accepted, level = 7. With level = 7, a 2-byte push in an ISSUE cycle → rejected, overflow = 1.
- Wrap-around: push and drain 6 bytes, then push 4 + 4 bytes → all 8 bytes emerge in order across the pointer wrap.
- Flush during BUSY with 3 bytes queued, plus a concurrent push → level = 0, overflow = 0, no further crc_cs. The in-flight byte still completes: crc_ready returns to 1 and done = 1.

Source files
------------

// File: rtl/crc_byte_feeder.sv
// Byte FIFO that feeds 1/2/4-byte bus pushes into the CRC engine one byte per write.
// Strobe two cycles after a push into an idle, empty feeder; pushes that don't fit are dropped whole and flagged.
module crc_byte_feeder #(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [1:0]    wr_len,
  input  logic [31:0]   wr_data,
  input  logic          wr_reflect,
  input  logic          flush,
  input  logic          crc_ready,
  output logic          crc_cs,
  output logic [1:0]    crc_rs,
  output logic [3:0]    crc_wrl,
  output logic [31:0]   crc_d,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          done
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, BUSY} state_e;

  state_e        state_q, state_d;
  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          cs_q, cs_d;
  logic [1:0]    rs_q, rs_d;
  logic [7:0]    byte_q, byte_d;
  logic [LW-1:0] push_n;
  logic          push_req, push_ok, pop;
  logic [8:0]    head;

  always_comb begin
    push_n = '0;
    unique case (wr_len)
      2'b00:   push_n = LW'(1);
      2'b01:   push_n = LW'(2);
      2'b10:   push_n = LW'(4);
      default: push_n = '0;
    endcase
  end

  // Free space is judged on the start-of-cycle level; a concurrent pop does not help.
  assign push_req = wr_en && (wr_len != 2'b11);
  assign push_ok  = push_req && !flush && (push_n <= (LW'(DEPTH) - level_q));
  assign pop      = (state_q == ISSUE) && !flush;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    cs_d     = 1'b0;
    rs_d     = 2'b00;
    byte_d   = 8'h00;
    if (flush) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(push_n);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + (push_ok ? push_n : LW'(0)) - LW'(pop);
      unique case (state_q)
        IDLE: begin
          if ((level_q != '0) && crc_ready) begin
            state_d = ISSUE;
            cs_d    = 1'b1;
            rs_d    = {1'b1, head[8]};
            byte_d  = head[7:0];
          end
        end
        ISSUE: state_d = HOLD;
        // Engine ready is not trustworthy until it has loaded its bit counter.
        HOLD:  state_d = BUSY;
        BUSY:  if (crc_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok && (LW'(i) < push_n))
        mem_q[wr_ptr_q + PW'(i)] <= {wr_reflect, wr_data[8*i +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cs_q     <= 1'b0;
      rs_q     <= 2'b00;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cs_q     <= cs_d;
      rs_q     <= rs_d;
      byte_q   <= byte_d;
    end
  end

  assign crc_cs   = cs_q;
  assign crc_rs   = rs_q;
  assign crc_wrl  = {3'b000, cs_q};
  assign crc_d    = {24'h000000, byte_q};
  assign level    = level_q;
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign overflow = ovf_q;
  assign done     = empty && (state_q == IDLE) && crc_ready;
endmodule
